cnt_seq_arbiter: RTL



---
 rtl/cnt_seq_arbiter_if.sv | 17 +
 rtl/cnt_seq_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/cnt_seq_arbiter_if.sv
// Bundle of request/grant and counter result signals shared between requesters
// and the cnt_seq_arbiter.
interface cnt_seq_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            busy;
  logic [W-1:0]    cnt;
  logic [W-1:0]    out;
  logic            out_valid;
  logic            done;

  modport master (output req, input gnt, busy, cnt, out, out_valid, done);
  modport slave  (input req, output gnt, busy, cnt, out, out_valid, done);
endinterface

// File: rtl/cnt_seq_arbiter.sv
// Round-robin arbiter sharing one two-phase ramp counter between NREQ requesters.
// Optional macro CNT_SEQ_ABORT_EN: dropping the granted REQ aborts the run.
module cnt_seq_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int TH1  = 7,
  parameter int TH2  = 20
) (
  input logic             clk,
  input logic             rst,
  cnt_seq_arbiter_if.slave bus
);
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [W-1:0]    TH1_V   = W'(TH1);
  localparam logic [W-1:0]    TH2_V   = W'(TH2);
  localparam logic [W-1:0]    STEP1   = W'(1);
  localparam logic [W-1:0]    STEP2   = W'(2);
  localparam logic [W-1:0]    OFFSET  = W'(8);
  localparam logic [NREQ-1:0] GNT_ONE = NREQ'(1);
`ifdef CNT_SEQ_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, RUN1 = 2'd1, RUN2 = 2'd2} state_t;

  state_t          state_r, state_s;
  logic [NREQ-1:0] gnt_r, gnt_s;
  logic [W-1:0]    cnt_r, cnt_s;
  logic [W-1:0]    out_r, out_s;
  logic            ov_r, ov_s;
  logic            done_r, done_s;
  logic            busy_r, busy_s;
  logic [SW-1:0]   rr_r, rr_s;
  logic [SW-1:0]   sel_r, sel_s;
  logic [SW-1:0]   pick_s;
  logic [SW-1:0]   next_ptr_s;
  logic            found_s;
  logic            hit_s;
  logic            abort_s;
  int              dist_s;
  int              best_s;

  // Round-robin search: the set request with the smallest distance above rr_r wins.
  always_comb begin
    pick_s = '0;
    best_s = NREQ;
    dist_s = 0;
    hit_s  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      dist_s = (i >= int'(rr_r)) ? (i - int'(rr_r)) : (i - int'(rr_r) + NREQ);
      hit_s  = bus.req[i] && (dist_s < best_s);
      pick_s = hit_s ? SW'(i) : pick_s;
      best_s = hit_s ? dist_s : best_s;
    end
    found_s    = (best_s < NREQ);
    next_ptr_s = (int'(sel_r) == NREQ - 1) ? '0 : (sel_r + SW'(1));
    abort_s    = ABORT_EN && (state_r != IDLE) && !bus.req[sel_r];
  end

  // Next-state and output computation; abort takes priority over a phase exit.
  always_comb begin
    state_s = state_r;
    gnt_s   = gnt_r;
    cnt_s   = cnt_r;
    out_s   = out_r;
    rr_s    = rr_r;
    sel_s   = sel_r;
    ov_s    = 1'b0;
    done_s  = 1'b0;
    if (abort_s) begin
      gnt_s   = '0;
      cnt_s   = '0;
      rr_s    = next_ptr_s;
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            sel_s   = pick_s;
            gnt_s   = GNT_ONE << pick_s;
            cnt_s   = '0;
            state_s = RUN1;
          end else begin
            state_s = IDLE;
          end
        end
        RUN1: begin
          cnt_s = cnt_r + STEP1;
          if (cnt_r > TH1_V) begin
            out_s   = cnt_r;
            ov_s    = 1'b1;
            state_s = RUN2;
          end else begin
            state_s = RUN1;
          end
        end
        RUN2: begin
          cnt_s = cnt_r + STEP2;
          if (cnt_r > TH2_V) begin
            out_s   = cnt_r - OFFSET;
            ov_s    = 1'b1;
            done_s  = 1'b1;
            gnt_s   = '0;
            rr_s    = next_ptr_s;
            state_s = IDLE;
          end else begin
            state_s = RUN2;
          end
        end
        default: begin
          gnt_s   = '0;
          state_s = IDLE;
        end
      endcase
    end
    busy_s = (state_s != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      gnt_r   <= '0;
      cnt_r   <= '0;
      out_r   <= '0;
      ov_r    <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
      rr_r    <= '0;
      sel_r   <= '0;
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      cnt_r   <= cnt_s;
      out_r   <= out_s;
      ov_r    <= ov_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
      rr_r    <= rr_s;
      sel_r   <= sel_s;
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.busy      = busy_r;
  assign bus.cnt       = cnt_r;
  assign bus.out       = out_r;
  assign bus.out_valid = ov_r;
  assign bus.done      = done_r;
endmodule
